// File: rtl/dice_pkg.sv
// Shared definitions for the dice roller controller: FSM states, default
// parameter values and counter widths.
package dice_pkg;

  localparam int unsigned DEB_CYCLES_DEF = 4;
  localparam int unsigned FAST_DIV_DEF   = 2;
  localparam int unsigned MAX_DIV_DEF    = 16;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned DBL_W   = CNT_W + 1;
  localparam int unsigned ROLLS_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    SLOW = 2'd2,
    SHOW = 2'd3
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a counter debouncer: db follows the
// synchronized input once it has differed for DEB_CYCLES consecutive cycles.
module btn_debounce
  import dice_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic db
);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      db    <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 != db) begin
        // the last differing cycle of the run commits the new level
        if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
          db  <= sync2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/dice_ctrl.sv
// Electronic dice controller: steps a downstream mod-6 counter quickly while
// the button is held, then slows down geometrically after release and settles.
module dice_ctrl
  import dice_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned FAST_DIV   = FAST_DIV_DEF,
  parameter int unsigned MAX_DIV    = MAX_DIV_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               button,
  output logic               step,
  output logic               dir,
  output logic               busy,
  output logic               done,
  output logic [ROLLS_W-1:0] rolls
);

  state_t             state, state_n;
  logic               db, db_q;
  logic [CNT_W-1:0]   tick, tick_n, tick_inc;
  logic [CNT_W-1:0]   interval, interval_n;
  logic [DBL_W-1:0]   interval_dbl;
  logic               last, last_n;
  logic               step_n, dir_n, busy_n, done_n;
  logic [ROLLS_W-1:0] rolls_n;
  logic               press_evt, rel_evt;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clock (clock),
    .reset (reset),
    .raw   (button),
    .db    (db)
  );

  assign press_evt    = db & ~db_q;
  assign rel_evt      = ~db & db_q;
  assign tick_inc     = tick + CNT_W'(1);
  assign interval_dbl = {interval, 1'b0};

  // State, counters and all outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      db_q     <= 1'b0;
      tick     <= '0;
      interval <= '0;
      last     <= 1'b0;
      step     <= 1'b0;
      dir      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rolls    <= '0;
    end else begin
      state    <= state_n;
      db_q     <= db;
      tick     <= tick_n;
      interval <= interval_n;
      last     <= last_n;
      step     <= step_n;
      dir      <= dir_n;
      busy     <= busy_n;
      done     <= done_n;
      rolls    <= rolls_n;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_n    = state;
    tick_n     = tick;
    interval_n = interval;
    last_n     = 1'b0;
    step_n     = 1'b0;
    dir_n      = dir;
    done_n     = 1'b0;
    rolls_n    = rolls;
    unique case (state)
      IDLE, SHOW: begin
        if (press_evt) begin
          state_n    = ROLL;
          dir_n      = ~dir;
          tick_n     = '0;
          interval_n = CNT_W'(FAST_DIV);
        end
      end
      ROLL: begin
        if (rel_evt) begin
          state_n    = SLOW;
          tick_n     = '0;
          interval_n = CNT_W'(2 * FAST_DIV);
        end else if (tick_inc == CNT_W'(FAST_DIV)) begin
          step_n = 1'b1;
          tick_n = '0;
        end else begin
          tick_n = tick_inc;
        end
      end
      SLOW: begin
        // last marks the cycle in which the final step is on the output
        if (last) begin
          state_n = SHOW;
          done_n  = 1'b1;
          if (rolls != '1) rolls_n = rolls + ROLLS_W'(1);
        end else if (tick_inc == interval) begin
          step_n = 1'b1;
          tick_n = '0;
          if (interval_dbl > DBL_W'(MAX_DIV)) last_n = 1'b1;
          else interval_n = interval_dbl[CNT_W-1:0];
        end else begin
          tick_n = tick_inc;
        end
      end
    endcase
    busy_n = (state_n == ROLL) || (state_n == SLOW);
  end

endmodule

// File: tb/tb_dice_ctrl.sv
// Directed self-checking bench for dice_ctrl with default parameters.
module tb_dice_ctrl;
  import dice_pkg::*;

  logic       clock, reset, button;
  logic       step, dir, busy, done;
  logic [7:0] rolls;
  int         n_checks = 0;
  int         n_errors = 0;

  dice_ctrl dut (
    .clock  (clock),
    .reset  (reset),
    .button (button),
    .step   (step),
    .dir    (dir),
    .busy   (busy),
    .done   (done),
    .rolls  (rolls)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Raise the button at the current negedge and count negedges until busy.
  task automatic press_wait(output int lat);
    button = 1'b1;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!busy && lat < 20);
  endtask

  // Sample the SLOW phase m = 0..34; optionally poke the button meanwhile.
  task automatic run_slow(input bit poke, input logic [7:0] exp_rolls);
    logic exp_step, exp_done, exp_busy;
    for (int m = 0; m < 35; m++) begin
      @(negedge clock);
      exp_step = (m == 4 || m == 12 || m == 28);
      exp_done = (m == 29);
      exp_busy = (m <= 28);
      n_checks++;
      if (step !== exp_step || done !== exp_done || busy !== exp_busy) begin
        n_errors++;
        $display("FAIL slow m=%0d: step/done/busy=%b%b%b expected %b%b%b",
                 m, step, done, busy, exp_step, exp_done, exp_busy);
      end
      if (m == 29) begin
        n_checks++;
        if (rolls !== exp_rolls) begin
          n_errors++;
          $display("FAIL slow_rolls: rolls=%0d expected %0d", rolls, exp_rolls);
        end
      end
      if (poke) begin
        if (m == 3)  button = 1'b1;
        if (m == 13) button = 1'b0;
        if (m == 20) button = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    button = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({step, dir, busy, done, rolls} !== 12'h000) begin
      n_errors++;
      $display("FAIL reset: step dir busy done rolls=%b %b %b %b %0d expected all 0",
               step, dir, busy, done, rolls);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_glitch;
    bit bad;
    bad = 1'b0;
    button = 1'b1;
    repeat (3) @(negedge clock);
    button = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (dut.u_deb.db !== 1'b0 || busy !== 1'b0 || step !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("FAIL glitch: db/busy/step rose on a 3-cycle pulse, expected all 0");
    end
  endtask

  task automatic test_roll;
    int   lat;
    logic exp_step;
    press_wait(lat);
    n_checks++;
    if (lat != 7) begin
      n_errors++;
      $display("FAIL roll_latency: busy after %0d cycles expected 7", lat);
    end
    n_checks++;
    if (dir !== 1'b1) begin
      n_errors++;
      $display("FAIL roll_dir: dir=%b expected 1", dir);
    end
    for (int k = 0; k < 46; k++) begin
      if (k > 0) @(negedge clock);
      exp_step = (k >= 2) && (k % 2 == 0);
      n_checks++;
      if (step !== exp_step || busy !== 1'b1) begin
        n_errors++;
        $display("FAIL roll k=%0d: step/busy=%b%b expected %b1", k, step, busy, exp_step);
      end
      if (k == 39) button = 1'b0;
    end
  endtask

  task automatic test_slowdown;
    run_slow(1'b0, 8'd1);
    n_checks++;
    if (busy !== 1'b0 || dir !== 1'b1) begin
      n_errors++;
      $display("FAIL slow_end: busy=%b dir=%b expected busy 0 dir 1", busy, dir);
    end
  endtask

  task automatic test_ignore_restart;
    int lat;
    repeat (5) @(negedge clock);
    press_wait(lat);
    n_checks++;
    if (lat != 7 || dir !== 1'b0) begin
      n_errors++;
      $display("FAIL restart2: latency=%0d dir=%b expected 7 and 0", lat, dir);
    end
    button = 1'b0;
    repeat (6) @(negedge clock);
    run_slow(1'b1, 8'd2);
    // button is still held here from a press made during SLOW
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      n_checks++;
      if (busy !== 1'b0 || step !== 1'b0) begin
        n_errors++;
        $display("FAIL held_show i=%0d: busy/step=%b%b expected 00", i, busy, step);
      end
    end
    button = 1'b0;
    repeat (12) @(negedge clock);
    press_wait(lat);
    n_checks++;
    if (lat != 7 || dir !== 1'b1) begin
      n_errors++;
      $display("FAIL restart3: latency=%0d dir=%b expected 7 and 1", lat, dir);
    end
  endtask

  task automatic test_reset_midroll;
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    button = 1'b0;
    #1;
    n_checks++;
    if ({step, dir, busy, done, rolls} !== 12'h000 || dut.state !== IDLE) begin
      n_errors++;
      $display("FAIL async_reset: step dir busy done rolls=%b %b %b %b %0d state=%0d expected 0s IDLE",
               step, dir, busy, done, rolls, dut.state);
    end
    repeat (5) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || step !== 1'b0) begin
        n_errors++;
        $display("FAIL post_reset i=%0d: done/busy/step=%b%b%b expected 000", i, done, busy, step);
      end
    end
    n_checks++;
    if (rolls !== 8'd0 || dir !== 1'b0) begin
      n_errors++;
      $display("FAIL post_reset_regs: rolls=%0d dir=%b expected 0 0", rolls, dir);
    end
  endtask

  task automatic test_saturation;
    int   lat, done_cnt;
    logic [7:0] exp_rolls;
    for (int r = 1; r <= 256; r++) begin
      @(negedge clock);
      press_wait(lat);
      n_checks++;
      if (lat != 7 || dir !== 1'(r % 2)) begin
        n_errors++;
        $display("FAIL sat_start r=%0d: latency=%0d dir=%b expected 7 %0d", r, lat, dir, r % 2);
      end
      button = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 45; i++) begin
        @(negedge clock);
        if (done === 1'b1) done_cnt++;
      end
      exp_rolls = (r > 255) ? 8'd255 : 8'(r);
      n_checks++;
      if (done_cnt != 1 || rolls !== exp_rolls || busy !== 1'b0) begin
        n_errors++;
        $display("FAIL sat r=%0d: done pulses=%0d rolls=%0d busy=%b expected 1 %0d 0",
                 r, done_cnt, rolls, busy, exp_rolls);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    button = 1'b0;
    test_reset;
    test_glitch;
    test_roll;
    test_slowdown;
    test_ignore_restart;
    test_reset_midroll;
    test_saturation;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dice_ctrl.md
DICE_CTRL -- requirements
Module: dice_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4: consecutive stable synchronized samples needed to accept a button change (range 2..255).
REQ-002 SHALL have parameter FAST_DIV, default 2: step interval in cycles while rolling (range 1..64).
REQ-003 SHALL have parameter MAX_DIV, default 16: largest allowed slow-down interval (range 2*FAST_DIV..128).
REQ-004 SHALL have ports, in this order: clock  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-high.
REQ-005 button  in  1  raw, asynchronous push-button input, 1 = pressed.
REQ-006 step  out  1  one-cycle pulse that advances the downstream mod-6 counter by one position.
REQ-007 dir  out  1  direction level for the downstream counter, 1 = count up.
REQ-008 busy  out  1  high in ROLL and SLOW.
REQ-009 done  out  1  one-cycle pulse when a roll has settled.
REQ-010 rolls  out  8  saturating count of completed rolls.

Function
REQ-011 button SHALL pass through a 2-flop synchronizer, then a debouncer; btn_db changes only after the synchronized value differs from btn_db for DEB_CYCLES consecutive cycles.
REQ-012 A press event SHALL be a 0->1 transition of btn_db; a release event SHALL be a 1->0 transition.
REQ-013 The FSM SHALL have the states IDLE, ROLL, SLOW and SHOW.
REQ-014 IDLE or SHOW plus a press SHALL go to ROLL, toggle dir, clear the tick counter and load interval = FAST_DIV.
REQ-015 In ROLL, step SHALL pulse on every cycle in which the tick counter reaches FAST_DIV; the tick counter then clears.
REQ-016 ROLL plus a release SHALL go to SLOW, clear the tick counter and load interval = 2*FAST_DIV; the release cycle emits no step.
REQ-017 In SLOW, step SHALL pulse when the tick counter reaches interval, and interval then doubles.
REQ-018 If the doubled interval exceeds MAX_DIV, the FSM SHALL go to SHOW on that same step.
REQ-019 done SHALL be high exactly on the first SHOW cycle; rolls SHALL increment in that same cycle and saturate at 255.
REQ-020 Presses during SLOW SHALL be ignored; a button still held on SHOW entry does not restart the roll (a new 0->1 btn_db transition is required).
REQ-021 step SHALL never be high in IDLE or SHOW.
REQ-022 dir SHALL hold its value between rolls.
REQ-023 The tick and interval counters SHALL be 8 bits wide; doubling SHALL be computed in 9 bits before the comparison so it cannot wrap.
REQ-024 busy SHALL be a registered decode of the state.

Reset
REQ-025 Assertion of reset SHALL immediately, regardless of clock, force: state=IDLE, step=0, done=0, busy=0, dir=0, rolls=0, counters=0, synchronizer and btn_db=0.
REQ-026 Reset asserted mid-roll SHALL abandon the roll with no done pulse; after release, a press is required to start again.

Structure
REQ-027 The state encoding and the default parameter values SHALL live in a shared package dice_pkg.
REQ-028 The synchronizer plus debouncer SHALL be a sub-module named btn_debounce (in: clock, reset, raw; out: db).
REQ-029 All outputs SHALL be registered.

Verification (defaults DEB_CYCLES=4, FAST_DIV=2, MAX_DIV=16)
REQ-030 Reset: hold reset high mid-ROLL -> all outputs 0 at once, state IDLE, no done pulse after release.
REQ-031 Glitch: raw button high for 3 cycles, then low -> btn_db stays 0, no step, busy stays 0.
REQ-032 Roll: hold button 40 cycles after debounce -> ROLL, step every 2nd cycle, dir=1, busy=1.
REQ-033 Slow-down: release -> exactly 3 further steps at 4, 12 and 28 cycles after SLOW entry; done the cycle after the third step; rolls=1; busy=0.
REQ-034 Ignore and restart: press during SLOW -> no effect; a press after SHOW -> new roll with dir=0; button held across SHOW entry -> no restart.
REQ-035 Saturation: 256 complete rolls -> rolls=255, done still pulses once per roll.
